pipeline_stall_controller: RTL

- Central hazard sequencer for the 5-stage CPU pipeline.
- Consumes the load-use hazard flag, multdiv start/ready and the X-stage branch-taken flag.
- Drives latch enables, nop-insertion selects and the multdiv start pulse.
- Sits beside the D/X and X/M latches. It replaces the ad-hoc stall wiring in the processor top level.

---
 rtl/pipeline_stall_controller_pkg.sv | 13 +
 rtl/pipeline_stall_controller_if.sv | 40 ++++
 rtl/pipeline_stall_controller_md_wait_counter.sv | 28 ++
 rtl/pipeline_stall_controller.sv | 135 +++++++++++++
 4 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared state encoding and default sizing for the pipeline stall controller.
package pipeline_stall_controller_pkg;

    typedef enum logic [1:0] {
        STATE_RUN         = 2'd0,
        STATE_LOAD_BUBBLE = 2'd1,
        STATE_MD_WAIT     = 2'd2
    } state_t;

    localparam int MD_TIMEOUT_DEFAULT = 40;
    localparam int CNT_W_DEFAULT      = 6;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard flags in and latch enables / nop selects / multdiv controls out.
// STALL_STATS_EN adds the stall_cycles and flush_count statistics outputs.
interface pipeline_stall_controller_if;
    logic        load_use;
    logic        md_op_x;
    logic        md_ready;
    logic        branch_taken_x;
    logic        pc_en;
    logic        fd_en;
    logic        dx_en;
    logic        fd_nop;
    logic        dx_nop;
    logic        xm_nop;
    logic        md_go;
    logic        md_busy;
    logic        md_timeout;
`ifdef STALL_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    modport master (
        input  load_use, md_op_x, md_ready, branch_taken_x,
        output pc_en, fd_en, dx_en, fd_nop, dx_nop, xm_nop,
        output md_go, md_busy, md_timeout
`ifdef STALL_STATS_EN
        , output stall_cycles, output flush_count
`endif
    );

    modport slave (
        output load_use, md_op_x, md_ready, branch_taken_x,
        input  pc_en, fd_en, dx_en, fd_nop, dx_nop, xm_nop,
        input  md_go, md_busy, md_timeout
`ifdef STALL_STATS_EN
        , input stall_cycles, input flush_count
`endif
    );

endinterface

// File: rtl/pipeline_stall_controller_md_wait_counter.sv
// Multdiv wait counter: clear, count-enable and terminal-count flag.
// Latency: tc is combinational from the registered count; no backpressure.
module md_wait_counter #(
    parameter int CNT_W = 6,
    parameter int TC    = 39
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == CNT_W'(TC));

endmodule

// File: rtl/pipeline_stall_controller.sv
// Hazard sequencer: stalls/flushes the 5-stage pipe for load-use, branches and multdiv.
// Latency: outputs decode combinationally from state+inputs; stalls via enables. Option: STALL_STATS_EN.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic                        clock,
    input  logic                        reset,
    pipeline_stall_controller_if.master ps
);

    state_t state;
    state_t state_nxt;
    logic   md_tc;
    logic   set_timeout;
    logic   timeout_q;
    logic   pc_en, fd_en, dx_en, fd_nop, dx_nop, xm_nop, md_go;

    md_wait_counter #(
        .CNT_W (CNT_W),
        .TC    (MD_TIMEOUT - 1)
    ) u_md_wait_counter (
        .clock (clock),
        .reset (reset),
        .clr   (state != STATE_MD_WAIT),
        .en    (state == STATE_MD_WAIT),
        .tc    (md_tc)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= STATE_RUN;
            timeout_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (set_timeout) begin
                timeout_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        set_timeout = 1'b0;
        pc_en       = 1'b1;
        fd_en       = 1'b1;
        dx_en       = 1'b1;
        fd_nop      = 1'b0;
        dx_nop      = 1'b0;
        xm_nop      = 1'b0;
        md_go       = 1'b0;
        case (state)
            STATE_RUN: begin
                if (ps.md_op_x) begin
                    md_go     = 1'b1;
                    xm_nop    = 1'b1;
                    pc_en     = 1'b0;
                    fd_en     = 1'b0;
                    dx_en     = 1'b0;
                    state_nxt = STATE_MD_WAIT;
                end else if (ps.branch_taken_x) begin
                    fd_nop = 1'b1;
                    dx_nop = 1'b1;
                end else if (ps.load_use) begin
                    pc_en     = 1'b0;
                    fd_en     = 1'b0;
                    dx_nop    = 1'b1;
                    state_nxt = STATE_LOAD_BUBBLE;
                end
            end
            // The bubble now in X is neither a lw nor a branch, so inputs are moot here.
            STATE_LOAD_BUBBLE: begin
                state_nxt = STATE_RUN;
            end
            STATE_MD_WAIT: begin
                pc_en  = 1'b0;
                fd_en  = 1'b0;
                dx_en  = 1'b0;
                xm_nop = 1'b1;
                if (ps.md_ready) begin
                    pc_en     = 1'b1;
                    fd_en     = 1'b1;
                    dx_en     = 1'b1;
                    xm_nop    = 1'b0;
                    state_nxt = STATE_RUN;
                end else if (md_tc) begin
                    // Abort: release the pipe but keep the garbage result out of X/M.
                    pc_en       = 1'b1;
                    fd_en       = 1'b1;
                    dx_en       = 1'b1;
                    set_timeout = 1'b1;
                    state_nxt   = STATE_RUN;
                end
            end
            default: begin
                state_nxt = STATE_RUN;
            end
        endcase
    end

    assign ps.pc_en      = pc_en;
    assign ps.fd_en      = fd_en;
    assign ps.dx_en      = dx_en;
    assign ps.fd_nop     = fd_nop;
    assign ps.dx_nop     = dx_nop;
    assign ps.xm_nop     = xm_nop;
    assign ps.md_go      = md_go;
    assign ps.md_busy    = (state == STATE_MD_WAIT);
    assign ps.md_timeout = timeout_q;

`ifdef STALL_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (!pc_en) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (fd_nop) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign ps.stall_cycles = stall_cycles_q;
    assign ps.flush_count  = flush_count_q;
`endif

endmodule
